// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Bit counter only needs to hold WIDTH-1, but never drops below one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_bitcell.sv
// One-bit full adder cell; kept standalone so it can be checked exhaustively.
module serial_adder_bitcell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sout,
    output logic cout
);
    assign sout = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one result bit per clock through a single full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_sum;
    logic             cell_cout;

    serial_adder_bitcell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sout (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Sum fills from the top so bit 0 ends up holding the LSB result.
                sum_d   = (sum_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
                carry_d = cell_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cout_d  = cell_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic/timing model plus directed literal vectors.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total  = 0;
    int passed = 0;
    int done_cnt8 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: an accepted request yields a+b+cin after WIDTH busy cycles.
    typedef struct {
        int left;
        int res;
        int sum;
        int cout;
        bit done;
    } model_t;

    model_t m8 = '{default: 0};
    model_t m1 = '{default: 0};

    function automatic model_t step(model_t m, bit start, int a, int b, int cin, int w);
        model_t n = m;
        if (n.left == 0 && start) begin
            n.left = w;
            n.res  = a + b + cin;
            n.sum  = 0;
            n.cout = 0;
            n.done = 0;
        end else if (n.left > 0) begin
            n.left--;
            if (n.left == 0) begin
                n.done = 1;
                n.sum  = n.res % (1 << w);
                n.cout = n.res / (1 << w);
            end
        end else begin
            n.done = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8 = '{default: 0};
            m1 = '{default: 0};
        end else begin
            m8 = step(m8, bus8.start, int'(bus8.a), int'(bus8.b), int'(bus8.cin), 8);
            m1 = step(m1, bus1.start, int'(bus1.a), int'(bus1.b), int'(bus1.cin), 1);
        end
    end

    always @(negedge clk) begin
        check("busy8", bus8.busy, m8.left > 0);
        check("done8", bus8.done, m8.done);
        if (m8.left == 0) begin
            check("sum8", bus8.sum, m8.sum);
            check("cout8", bus8.cout, m8.cout);
        end
        check("busy1", bus1.busy, m1.left > 0);
        check("done1", bus1.done, m1.done);
        if (m1.left == 0) begin
            check("sum1", bus1.sum, m1.sum);
            check("cout1", bus1.cout, m1.cout);
        end
        if (bus8.done) done_cnt8++;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input logic [7:0] es, input logic ec);
        int lat;
        int busy_n;
        bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.start = 1'b1;
        cyc();
        bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.cin = ~ci;
        lat = 1;
        busy_n = 0;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) busy_n++;
            cyc();
            lat++;
        end
        check("latency8", lat, 9);
        check("busy_cycles8", busy_n, 8);
        check("op_sum8", bus8.sum, es);
        check("op_cout8", bus8.cout, ec);
    endtask

    initial begin
        int d0;
        int prev;
        int n;
        int lat;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        cyc();
        cyc();
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_sum", bus8.sum, 0);
        check("rst_cout", bus8.cout, 0);
        rst = 1'b0;
        cyc();

        run_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        repeat (3) cyc();

        // Restart during RUN must be ignored.
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
        cyc();
        bus8.start = 1'b0;
        cyc();
        cyc();
        d0 = done_cnt8;
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
        cyc();
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        n = 0;
        while (!bus8.done && n < 40) begin cyc(); n++; end
        check("ignore_sum", bus8.sum, 8'h30);
        check("ignore_cout", bus8.cout, 0);
        repeat (12) cyc();
        check("ignore_done_count", done_cnt8 - d0, 1);

        // Reset in the middle of an operation.
        bus8.a = 8'h55; bus8.b = 8'h11; bus8.start = 1'b1;
        cyc();
        bus8.start = 1'b0;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        check("async_busy", bus8.busy, 0);
        check("async_done", bus8.done, 0);
        check("async_sum", bus8.sum, 0);
        check("async_cout", bus8.cout, 0);
        cyc();
        rst = 1'b0;
        d0 = done_cnt8;
        repeat (12) cyc();
        check("abort_no_done", done_cnt8 - d0, 0);
        run_op8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
        repeat (2) cyc();

        // Start held high: back-to-back results.
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
        prev = -1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (bus8.done) begin
                check("held_sum", bus8.sum, 8'h00);
                check("held_cout", bus8.cout, 1);
                if (prev >= 0) check("held_period", i - prev, 9);
                prev = i;
                n++;
            end
        end
        check("held_done_count", n, 3);
        bus8.start = 1'b0;
        repeat (12) cyc();

        // WIDTH=1: every input combination through the cell.
        for (int i = 0; i < 8; i++) begin
            bus1.a = 1'((i >> 2) & 1);
            bus1.b = 1'((i >> 1) & 1);
            bus1.cin = 1'(i & 1);
            bus1.start = 1'b1;
            cyc();
            bus1.start = 1'b0;
            lat = 1;
            while (!bus1.done && lat < 10) begin cyc(); lat++; end
            check("w1_latency", lat, 2);
            check("w1_result", {bus1.cout, bus1.sum},
                  ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
            cyc();
        end

        repeat (2) cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
